// File: rtl/osr_pull_ctrl.sv
// OSR refill / autopull / PULL-instruction control for a state-machine TX path.
// Strobes are combinational from the registered stall FSM; stall_count is a saturating counter.
module osr_pull_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        sm_enable,
    input  logic        autopull_en,
    input  logic        instr_out_valid,
    input  logic        instr_pull_valid,
    input  logic        pull_block,
    input  logic        pull_ifempty,
    input  logic [31:0] x_data,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    input  logic        osr_empty,
    input  logic        osr_request_refill,
    input  logic        stall_cnt_clr,
    output logic        fifo_pop,
    output logic        osr_refill_now,
    output logic [31:0] osr_refill_data,
    output logic        osr_out_enable,
    output logic        instr_done,
    output logic        stall,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        OUT_STALL  = 2'd1,
        PULL_STALL = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   use_x;

    assign state           = state_q;
    assign osr_refill_data = use_x ? x_data : fifo_data;

    always_comb begin
        state_d        = state_q;
        fifo_pop       = 1'b0;
        osr_refill_now = 1'b0;
        osr_out_enable = 1'b0;
        instr_done     = 1'b0;
        stall          = 1'b0;
        use_x          = 1'b0;
        // Reset is folded in here so strobes stay quiet while it is held.
        if (!reset || !sm_enable) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (instr_pull_valid) begin
                        if (pull_ifempty && !osr_empty) begin
                            instr_done = 1'b1;
                        end else if (!fifo_empty) begin
                            osr_refill_now = 1'b1;
                            fifo_pop       = 1'b1;
                            instr_done     = 1'b1;
                        end else if (pull_block) begin
                            stall   = 1'b1;
                            state_d = PULL_STALL;
                        end else begin
                            osr_refill_now = 1'b1;
                            use_x          = 1'b1;
                            instr_done     = 1'b1;
                        end
                    end else if (instr_out_valid) begin
                        if (autopull_en && osr_empty && !fifo_empty) begin
                            osr_refill_now = 1'b1;
                            fifo_pop       = 1'b1;
                            stall          = 1'b1;
                        end else if (autopull_en && osr_empty) begin
                            stall   = 1'b1;
                            state_d = OUT_STALL;
                        end else begin
                            osr_out_enable = 1'b1;
                            instr_done     = 1'b1;
                            if (osr_request_refill && !fifo_empty) begin
                                osr_refill_now = 1'b1;
                                fifo_pop       = 1'b1;
                            end
                        end
                    end else if (autopull_en && osr_empty && !fifo_empty) begin
                        osr_refill_now = 1'b1;
                        fifo_pop       = 1'b1;
                    end
                end
                OUT_STALL: begin
                    if (!instr_out_valid) begin
                        state_d = RUN;
                    end else if (fifo_empty) begin
                        stall = 1'b1;
                    end else begin
                        osr_refill_now = 1'b1;
                        fifo_pop       = 1'b1;
                        stall          = 1'b1;
                        state_d        = RUN;
                    end
                end
                PULL_STALL: begin
                    if (!instr_pull_valid) begin
                        state_d = RUN;
                    end else if (fifo_empty) begin
                        stall = 1'b1;
                    end else begin
                        osr_refill_now = 1'b1;
                        fifo_pop       = 1'b1;
                        instr_done     = 1'b1;
                        state_d        = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_count <= '0;
        end else begin
            state_q <= state_d;
            if (stall_cnt_clr)
                stall_count <= '0;
            else if (stall && stall_count != '1)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_osr_pull_ctrl.sv
// Randomized and directed checks of osr_pull_ctrl against a rule-level reference model.
module tb_osr_pull_ctrl;

    logic        clk = 1'b0;
    logic        reset, sm_enable, autopull_en, instr_out_valid, instr_pull_valid;
    logic        pull_block, pull_ifempty, fifo_empty, osr_empty, osr_request_refill, stall_cnt_clr;
    logic [31:0] x_data, fifo_data;
    logic        fifo_pop, osr_refill_now, osr_out_enable, instr_done, stall;
    logic [31:0] osr_refill_data;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model: which instruction (if any) is parked waiting on the FIFO, plus the stall tally.
    int m_wait = 0; // 0 none, 1 OUT parked, 2 PULL parked
    int m_cnt  = 0;

    always #5 clk = ~clk;

    osr_pull_ctrl dut (
        .clk(clk), .reset(reset), .sm_enable(sm_enable), .autopull_en(autopull_en),
        .instr_out_valid(instr_out_valid), .instr_pull_valid(instr_pull_valid),
        .pull_block(pull_block), .pull_ifempty(pull_ifempty), .x_data(x_data),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .osr_empty(osr_empty),
        .osr_request_refill(osr_request_refill), .stall_cnt_clr(stall_cnt_clr),
        .fifo_pop(fifo_pop), .osr_refill_now(osr_refill_now), .osr_refill_data(osr_refill_data),
        .osr_out_enable(osr_out_enable), .instr_done(instr_done), .stall(stall),
        .state(state), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          pop, refill, oe, done, stl;
        logic [31:0] rdata;
        int          nxt;
    } exp_t;

    function automatic exp_t model();
        exp_t e;
        bit refill_fifo, refill_x;
        e = '{default: 0};
        e.rdata = fifo_data;
        refill_fifo = 0;
        refill_x = 0;
        if (!reset || !sm_enable) return e;
        if (m_wait == 1) begin
            if (instr_out_valid) begin
                e.stl = 1;
                if (!fifo_empty) refill_fifo = 1; else e.nxt = 1;
            end
        end else if (m_wait == 2) begin
            if (instr_pull_valid) begin
                if (!fifo_empty) begin refill_fifo = 1; e.done = 1; end
                else begin e.stl = 1; e.nxt = 2; end
            end
        end else if (instr_pull_valid) begin
            if (pull_ifempty && !osr_empty) e.done = 1;
            else if (!fifo_empty)           begin refill_fifo = 1; e.done = 1; end
            else if (pull_block)            begin e.stl = 1; e.nxt = 2; end
            else                            begin refill_x = 1; e.done = 1; end
        end else if (instr_out_valid) begin
            if (autopull_en && osr_empty) begin
                e.stl = 1;
                if (!fifo_empty) refill_fifo = 1; else e.nxt = 1;
            end else begin
                e.oe = 1;
                e.done = 1;
                refill_fifo = osr_request_refill && !fifo_empty;
            end
        end else begin
            refill_fifo = autopull_en && osr_empty && !fifo_empty;
        end
        e.pop    = refill_fifo;
        e.refill = refill_fifo || refill_x;
        if (refill_x) e.rdata = x_data;
        return e;
    endfunction

    // Inputs are set just after a falling edge; check mid-low-phase, then advance one cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (!reset) begin m_wait = 0; m_cnt = 0; end
        e = model();
        chk("pop",    fifo_pop,        e.pop);
        chk("refill", osr_refill_now,  e.refill);
        chk("rdata",  osr_refill_data, e.rdata);
        chk("oe",     osr_out_enable,  e.oe);
        chk("done",   instr_done,      e.done);
        chk("stall",  stall,           e.stl);
        chk("state",  state,           m_wait);
        chk("cnt",    stall_count,     m_cnt);
        if (reset) begin
            m_wait = e.nxt;
            if (stall_cnt_clr)              m_cnt = 0;
            else if (e.stl && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1; sm_enable = 1; autopull_en = 0; instr_out_valid = 0; instr_pull_valid = 0;
        pull_block = 0; pull_ifempty = 0; fifo_empty = 1; osr_empty = 0;
        osr_request_refill = 0; stall_cnt_clr = 0; x_data = '0; fifo_data = '0;
    endtask

    task automatic clear_cnt();
        idle_inputs();
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        fifo_data = 32'hA5A5_0001;
        fifo_empty = 0; instr_pull_valid = 1; autopull_en = 1; osr_empty = 1;
        @(negedge clk);
        tick();
        tick();
        idle_inputs();
        tick();

        // Autopull OUT stalls three cycles on empty FIFO, refills on the fourth, completes on the fifth.
        clear_cnt();
        autopull_en = 1; osr_empty = 1; fifo_empty = 1; instr_out_valid = 1;
        repeat (3) tick();
        fifo_empty = 0; fifo_data = 32'hDEAD_BEEF;
        #1 chk("r42_refill", osr_refill_now, 1);
        chk("r42_data", osr_refill_data, 32'hDEAD_BEEF);
        tick();
        osr_empty = 0;
        #1 chk("r42_done", instr_done, 1);
        chk("r42_cnt", stall_count, 16'd4);
        tick();

        // Non-blocking PULL on empty FIFO loads X.
        idle_inputs();
        instr_pull_valid = 1; x_data = 32'h1234_5678; fifo_data = 32'h0BAD_0BAD;
        #1 chk("r43_data", osr_refill_data, 32'h1234_5678);
        chk("r43_pop", fifo_pop, 0);
        tick();

        // Blocking PULL waits two cycles, then completes.
        idle_inputs();
        instr_pull_valid = 1; pull_block = 1;
        tick();
        #1 chk("r44_state", state, 2);
        tick();
        fifo_empty = 0; fifo_data = 32'hCAFE_F00D;
        tick();
        #1 chk("r44_back", state, 0);
        tick();

        // OUT with refill request and data available: all four strobes together.
        idle_inputs();
        instr_out_valid = 1; osr_request_refill = 1; fifo_empty = 0; fifo_data = 32'h5555_AAAA;
        tick();

        // PULL wins over OUT; ifempty no-op.
        idle_inputs();
        instr_pull_valid = 1; instr_out_valid = 1; pull_ifempty = 1; fifo_empty = 0;
        #1 chk("r46_oe", osr_out_enable, 0);
        tick();

        // sm_enable drop mid-stall, then reset mid-stall.
        idle_inputs();
        instr_pull_valid = 1; pull_block = 1;
        tick(); tick();
        sm_enable = 0; fifo_empty = 0;
        tick();
        sm_enable = 1; fifo_empty = 1;
        tick(); tick();
        reset = 0; fifo_empty = 0;
        #1 chk("r41_pop", fifo_pop, 0);
        tick();
        reset = 1; fifo_empty = 1;
        tick();

        // Saturation: run the counter up to 0xFFFE, then past the ceiling, then clear.
        clear_cnt();
        instr_pull_valid = 1; pull_block = 1;
        repeat (65534) tick();
        #1 chk("r47_fffe", stall_count, 16'hFFFE);
        repeat (3) tick();
        #1 chk("r47_sat", stall_count, 16'hFFFF);
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
        #1 chk("r47_clr", stall_count, 16'h0000);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 99) != 0);
            sm_enable          = ($urandom_range(0, 19) != 0);
            autopull_en        = $urandom_range(0, 1);
            instr_out_valid    = ($urandom_range(0, 2) != 0);
            instr_pull_valid   = ($urandom_range(0, 2) == 0);
            pull_block         = $urandom_range(0, 1);
            pull_ifempty       = $urandom_range(0, 1);
            fifo_empty         = ($urandom_range(0, 2) == 0);
            osr_empty          = $urandom_range(0, 1);
            osr_request_refill = $urandom_range(0, 1);
            stall_cnt_clr      = ($urandom_range(0, 49) == 0);
            x_data             = $urandom;
            fifo_data          = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osr_pull_ctrl.md
OSR_PULL_CTRL -- requirements
Module: osr_pull_ctrl

Interface
REQ-001 SHALL: clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL: reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL: sm_enable, input, 1, state-machine enable; 0 forces state RUN and all strobes to 0.
REQ-004 SHALL: autopull_en, input, 1, autopull enable.
REQ-005 SHALL: instr_out_valid, input, 1, OUT instruction presented this cycle.
REQ-006 SHALL: instr_pull_valid, input, 1, PULL instruction presented this cycle.
REQ-007 SHALL: pull_block, input, 1, PULL blocks on empty FIFO.
REQ-008 SHALL: pull_ifempty, input, 1, PULL is a no-op unless the OSR is empty.
REQ-009 SHALL: x_data, input, 32, scratch X value loaded by a non-blocking PULL on an empty FIFO.
REQ-010 SHALL: fifo_empty, input, 1, TX FIFO empty flag.
REQ-011 SHALL: fifo_data, input, 32, TX FIFO head word.
REQ-012 SHALL: osr_empty, input, 1, OSR empty flag.
REQ-013 SHALL: osr_request_refill, input, 1, OSR autopull request.
REQ-014 SHALL: stall_cnt_clr, input, 1, synchronous clear of stall_count.
REQ-015 SHALL: fifo_pop, output, 1, pop the TX FIFO head this cycle.
REQ-016 SHALL: osr_refill_now, output, 1, load osr_refill_data into the OSR this cycle.
REQ-017 SHALL: osr_refill_data, output, 32, fifo_data, or x_data on a non-blocking empty-FIFO PULL.
REQ-018 SHALL: osr_out_enable, output, 1, perform the OSR shift this cycle.
REQ-019 SHALL: instr_done, output, 1, the presented instruction completes this cycle.
REQ-020 SHALL: stall, output, 1, the presented instruction must be re-presented next cycle.
REQ-021 SHALL: state, output, 2, RUN=0, OUT_STALL=1, PULL_STALL=2.
REQ-022 SHALL: stall_count, output, 16, saturating count of stall cycles.

Function
REQ-023 SHALL: all strobe outputs are combinational from the current state and inputs; the FSM and stall_count are registered.
REQ-024 SHALL: fifo_pop equals osr_refill_now whenever osr_refill_data selects fifo_data; fifo_pop never asserts while fifo_empty=1.
REQ-025 SHALL: if instr_pull_valid and instr_out_valid are both 1, PULL takes priority and the OUT is ignored (no done, no stall).
REQ-026 SHALL: in RUN, for an OUT with autopull_en=1 and osr_empty=1 and fifo_empty=0, assert refill and pop with osr_out_enable=0 and stall=1; the OUT completes on retry.
REQ-027 SHALL: in RUN, for an OUT with autopull_en=1 and osr_empty=1 and fifo_empty=1, assert stall=1 and go to OUT_STALL.
REQ-028 SHALL: for any other OUT in RUN, assert osr_out_enable=1 and instr_done=1; if osr_request_refill=1 and fifo_empty=0, also assert refill and pop in the same cycle.
REQ-029 SHALL: in RUN, a PULL with pull_ifempty=1 and osr_empty=0 asserts instr_done only.
REQ-030 SHALL: otherwise, a PULL with fifo_empty=0 asserts refill, pop and instr_done.
REQ-031 SHALL: otherwise, a PULL with pull_block=1 asserts stall and goes to PULL_STALL.
REQ-032 SHALL: otherwise, a PULL refills the OSR from x_data with no pop and asserts instr_done.
REQ-033 SHALL: in RUN with no instruction, autopull_en=1, osr_empty=1 and fifo_empty=0, perform a background refill and pop.
REQ-034 SHALL: in OUT_STALL, while fifo_empty=1 assert stall; at the first cycle with fifo_empty=0, refill, pop, keep stall=1 and return to RUN.
REQ-035 SHALL: in OUT_STALL, instr_out_valid=0 returns the FSM to RUN with no strobes.
REQ-036 SHALL: in PULL_STALL, while fifo_empty=1 assert stall; at fifo_empty=0, refill, pop, assert instr_done and return to RUN.
REQ-037 SHALL: in PULL_STALL, instr_pull_valid=0 returns the FSM to RUN with no strobes.
REQ-038 SHALL: stall_count increments each cycle stall=1 and saturates at 16'hFFFF; stall_cnt_clr has priority and zeroes it the next cycle.
REQ-039 SHALL: sm_enable=0 mid-stall returns the FSM to RUN next cycle, holds stall_count, and produces no pop.

Reset
REQ-040 SHALL: while reset=0, state=RUN, stall_count=0, and fifo_pop, osr_refill_now, osr_out_enable, instr_done and stall are all 0; osr_refill_data=fifo_data.
REQ-041 SHALL: reset asserted mid-stall aborts the stall immediately, with no pop.

Verification
REQ-042 SHALL: autopull_en=1, osr_empty=1, FIFO empty, OUT held 3 cycles, then FIFO gets 0xDEADBEEF -> stall for 4 cycles with refill on the 4th, done on the 5th; stall_count=4.
REQ-043 SHALL: non-blocking PULL with FIFO empty and x_data=0x12345678 -> refill_data=0x12345678, no pop, done in 1 cycle.
REQ-044 SHALL: blocking PULL with FIFO empty for 2 cycles -> state=2, then refill+pop+done in cycle 3, then state=0.
REQ-045 SHALL: OUT with osr_request_refill=1 and FIFO non-empty -> osr_out_enable, refill, pop and done all in the same cycle.
REQ-046 SHALL: PULL and OUT both valid with pull_ifempty=1 and osr_empty=0 -> done=1, out_enable=0, no pop.
REQ-047 SHALL: stall_count preloaded to 16'hFFFE plus 3 stall cycles -> 16'hFFFF; stall_cnt_clr -> 0.
